store_buffer: RTL and testbench



---
 rtl/store_buffer_pkg.sv | 19 +
 rtl/sb_fwd_match.sv | 34 +++
 rtl/store_buffer.sv | 126 ++++++++++++
 tb/tb_store_buffer.sv | 248 ++++++++++++++++++++++++
 4 files changed

// File: rtl/store_buffer_pkg.sv
// Shared types, default sizes and pointer helper for the store buffer.
// Entry field widths follow SB_ADDR_W/SB_DATA_W; change ADDR_W/DATA_W here together with them.
package store_buffer_pkg;

    localparam int SB_DEPTH  = 4;
    localparam int SB_ADDR_W = 32;
    localparam int SB_DATA_W = 32;

    typedef struct packed {
        logic                 valid;
        logic [SB_ADDR_W-1:0] addr;
        logic [SB_DATA_W-1:0] data;
    } sb_entry_t;

    function automatic int unsigned sb_ptr_inc(input int unsigned ptr, input int unsigned depth);
        return (ptr == depth - 1) ? 0 : ptr + 1;
    endfunction

endpackage

// File: rtl/sb_fwd_match.sv
// Load-forwarding compare: scans queued entries oldest to youngest so the
// youngest matching store wins.
module sb_fwd_match
    import store_buffer_pkg::*;
#(
    parameter int DEPTH = SB_DEPTH,
    parameter int PTR_W = $clog2(DEPTH),
    parameter int CNT_W = $clog2(DEPTH) + 1
) (
    input  sb_entry_t            entries [DEPTH],
    input  logic [PTR_W-1:0]     head,
    input  logic [CNT_W-1:0]     count,
    input  logic [SB_ADDR_W-1:0] ld_addr,
    output logic                 hit,
    output logic [SB_DATA_W-1:0] data
);

    logic [PTR_W-1:0] idx;

    // DEPTH is a power of two, so truncating head+i wraps the ring for free
    always_comb begin
        hit  = 1'b0;
        data = '0;
        idx  = '0;
        for (int i = 0; i < DEPTH; i++) begin
            idx = head + PTR_W'(i);
            if ((CNT_W'(i) < count) && entries[idx].valid && (entries[idx].addr == ld_addr)) begin
                hit  = 1'b1;
                data = entries[idx].data;
            end
        end
    end

endmodule

// File: rtl/store_buffer.sv
// FIFO write buffer in front of data memory: drains when no load needs the port,
// forwards queued data to loads. Optional STORE_BUFFER_COALESCE_EN merges same-address stores.
module store_buffer
    import store_buffer_pkg::*;
#(
    parameter int DEPTH  = SB_DEPTH,
    parameter int ADDR_W = SB_ADDR_W,
    parameter int DATA_W = SB_DATA_W
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              st_valid,
    output logic              st_ready,
    input  logic [ADDR_W-1:0] st_addr,
    input  logic [DATA_W-1:0] st_data,
    input  logic              ld_req,
    input  logic [ADDR_W-1:0] ld_addr,
    output logic [DATA_W-1:0] ld_data,
    output logic              ld_fwd,
    output logic              empty,
    output logic              mem_write_enable,
    output logic              mem_read_enable,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_write_data,
    input  logic [DATA_W-1:0] mem_read_data
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH) + 1;

    sb_entry_t         entries [DEPTH];
    logic [PTR_W-1:0]  head;
    logic [PTR_W-1:0]  tail;
    logic [CNT_W-1:0]  count;
    logic              full;
    logic              drain;
    logic              accept;
    logic              push;
    logic              st_match;
    logic              fwd_hit;
    logic [DATA_W-1:0] fwd_data;

    assign full  = (count == CNT_W'(DEPTH));
    assign empty = (count == '0);
    assign drain = !empty && !ld_req;

`ifdef STORE_BUFFER_COALESCE_EN
    logic [PTR_W-1:0] match_idx;

    // The head leaving this cycle cannot absorb a store; the store allocates instead
    always_comb begin
        st_match  = 1'b0;
        match_idx = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (entries[i].valid && (entries[i].addr == st_addr) &&
                !(drain && (PTR_W'(i) == head))) begin
                st_match  = 1'b1;
                match_idx = PTR_W'(i);
            end
        end
    end
`else
    assign st_match = 1'b0;
`endif

    assign st_ready = !full || st_match;
    assign accept   = st_valid && st_ready;
    assign push     = accept && (st_addr != '0) && !st_match;

    sb_fwd_match #(
        .DEPTH (DEPTH),
        .PTR_W (PTR_W),
        .CNT_W (CNT_W)
    ) u_fwd_match (
        .entries (entries),
        .head    (head),
        .count   (count),
        .ld_addr (ld_addr),
        .hit     (fwd_hit),
        .data    (fwd_data)
    );

    assign ld_fwd  = ld_req && fwd_hit;
    assign ld_data = !ld_req ? '0 : (fwd_hit ? fwd_data : mem_read_data);

    // A load owns the memory port; otherwise the head entry drains
    always_comb begin
        mem_read_enable  = ld_req;
        mem_write_enable = drain;
        mem_addr         = '0;
        mem_write_data   = '0;
        if (ld_req) begin
            mem_addr = ld_addr;
        end else if (drain) begin
            mem_addr       = entries[head].addr;
            mem_write_data = entries[head].data;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                entries[i] <= '0;
            end
        end else begin
            if (drain) begin
                entries[head].valid <= 1'b0;
                head                <= PTR_W'(sb_ptr_inc(32'(head), DEPTH));
            end
            if (push) begin
                entries[tail] <= '{valid: 1'b1, addr: st_addr, data: st_data};
                tail          <= PTR_W'(sb_ptr_inc(32'(tail), DEPTH));
            end
`ifdef STORE_BUFFER_COALESCE_EN
            if (accept && st_match) begin
                entries[match_idx].data <= st_data;
            end
`endif
            count <= count + CNT_W'(push) - CNT_W'(drain);
        end
    end

endmodule

// File: tb/tb_store_buffer.sv
// Directed testbench for store_buffer: reset, fill/drain order, forwarding,
// load priority, address-0 stores, async reset mid-drain and wrap-around streaming.
module tb_store_buffer;

    logic        clk;
    logic        reset;
    logic        st_valid;
    logic        st_ready;
    logic [31:0] st_addr;
    logic [31:0] st_data;
    logic        ld_req;
    logic [31:0] ld_addr;
    logic [31:0] ld_data;
    logic        ld_fwd;
    logic        empty;
    logic        mem_write_enable;
    logic        mem_read_enable;
    logic [31:0] mem_addr;
    logic [31:0] mem_write_data;
    logic [31:0] mem_read_data;

    logic [31:0] mem [16];
    int          checks;
    int          failures;

`ifdef STORE_BUFFER_COALESCE_EN
    localparam logic [31:0] FIRST_DRAIN_5 = 32'h22;
`else
    localparam logic [31:0] FIRST_DRAIN_5 = 32'h11;
`endif

    store_buffer dut (
        .clk              (clk),
        .reset            (reset),
        .st_valid         (st_valid),
        .st_ready         (st_ready),
        .st_addr          (st_addr),
        .st_data          (st_data),
        .ld_req           (ld_req),
        .ld_addr          (ld_addr),
        .ld_data          (ld_data),
        .ld_fwd           (ld_fwd),
        .empty            (empty),
        .mem_write_enable (mem_write_enable),
        .mem_read_enable  (mem_read_enable),
        .mem_addr         (mem_addr),
        .mem_write_data   (mem_write_data),
        .mem_read_data    (mem_read_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Small data memory behind the buffer
    always @(posedge clk) begin
        if (mem_write_enable) mem[mem_addr[3:0]] <= mem_write_data;
    end
    assign mem_read_data = mem[mem_addr[3:0]];

    task automatic drive(input logic sv, input logic [31:0] sa, input logic [31:0] sd,
                         input logic lr, input logic [31:0] la);
        @(negedge clk);
        st_valid = sv;
        st_addr  = sa;
        st_data  = sd;
        ld_req   = lr;
        ld_addr  = la;
        #1;
    endtask

    task automatic test_reset;
        reset = 1'b1;
        drive(1'b0, 32'h0, 32'h0, 1'b0, 32'h0);
        checks++; if (st_ready !== 1'b1) begin failures++; $display("[TB] FAIL reset_st_ready got=%b exp=1", st_ready); end
        checks++; if (empty !== 1'b1) begin failures++; $display("[TB] FAIL reset_empty got=%b exp=1", empty); end
        checks++; if (mem_write_enable !== 1'b0) begin failures++; $display("[TB] FAIL reset_wen got=%b exp=0", mem_write_enable); end
        checks++; if (ld_fwd !== 1'b0) begin failures++; $display("[TB] FAIL reset_fwd got=%b exp=0", ld_fwd); end
        @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic test_fill_drain;
        for (int i = 1; i <= 4; i++) begin
            drive(1'b1, 32'(i), 32'hA0 + 32'(i), 1'b1, 32'd15);
            checks++; if (st_ready !== 1'b1) begin failures++; $display("[TB] FAIL fill_ready_%0d got=%b exp=1", i, st_ready); end
        end
        drive(1'b1, 32'd5, 32'hA5, 1'b1, 32'd15);
        checks++; if (st_ready !== 1'b0) begin failures++; $display("[TB] FAIL full_ready got=%b exp=0", st_ready); end
        checks++; if (empty !== 1'b0) begin failures++; $display("[TB] FAIL full_empty got=%b exp=0", empty); end
        checks++; if (mem_write_enable !== 1'b0 || mem_read_enable !== 1'b1) begin
            failures++; $display("[TB] FAIL full_load_prio got wen=%b ren=%b exp wen=0 ren=1", mem_write_enable, mem_read_enable);
        end
        drive(1'b1, 32'd5, 32'hA5, 1'b0, 32'd0);
        checks++; if (st_ready !== 1'b0) begin failures++; $display("[TB] FAIL full_no_lookahead got=%b exp=0", st_ready); end
        checks++; if (mem_write_enable !== 1'b1 || mem_addr !== 32'd1 || mem_write_data !== 32'hA1) begin
            failures++; $display("[TB] FAIL drain_1 got wen=%b addr=%h data=%h exp 1/1/a1", mem_write_enable, mem_addr, mem_write_data);
        end
        for (int i = 2; i <= 4; i++) begin
            drive(1'b0, 32'h0, 32'h0, 1'b0, 32'h0);
            checks++; if (mem_write_enable !== 1'b1 || mem_addr !== 32'(i) || mem_write_data !== 32'hA0 + 32'(i)) begin
                failures++; $display("[TB] FAIL drain_%0d got wen=%b addr=%h data=%h exp addr=%0d", i, mem_write_enable, mem_addr, mem_write_data, i);
            end
        end
        drive(1'b0, 32'h0, 32'h0, 1'b0, 32'h0);
        checks++; if (empty !== 1'b1 || mem_write_enable !== 1'b0 || mem_addr !== 32'h0) begin
            failures++; $display("[TB] FAIL drained_idle got empty=%b wen=%b addr=%h exp 1/0/0", empty, mem_write_enable, mem_addr);
        end
    endtask

    task automatic test_latency;
        drive(1'b1, 32'd9, 32'h99, 1'b0, 32'h0);
        checks++; if (mem_write_enable !== 1'b0 || st_ready !== 1'b1) begin
            failures++; $display("[TB] FAIL latency_same_cycle got wen=%b ready=%b exp 0/1", mem_write_enable, st_ready);
        end
        drive(1'b0, 32'h0, 32'h0, 1'b0, 32'h0);
        checks++; if (mem_write_enable !== 1'b1 || mem_addr !== 32'd9 || mem_write_data !== 32'h99) begin
            failures++; $display("[TB] FAIL latency_next got wen=%b addr=%h data=%h exp 1/9/99", mem_write_enable, mem_addr, mem_write_data);
        end
        drive(1'b0, 32'h0, 32'h0, 1'b0, 32'h0);
        checks++; if (empty !== 1'b1) begin failures++; $display("[TB] FAIL latency_empty got=%b exp=1", empty); end
    endtask

    task automatic test_forward;
        drive(1'b1, 32'd5, 32'h11, 1'b1, 32'd5);
        checks++; if (ld_fwd !== 1'b0 || ld_data !== 32'h0) begin
            failures++; $display("[TB] FAIL fwd_same_cycle got fwd=%b data=%h exp 0/0", ld_fwd, ld_data);
        end
        drive(1'b1, 32'd5, 32'h22, 1'b1, 32'd5);
        checks++; if (ld_fwd !== 1'b1 || ld_data !== 32'h11) begin
            failures++; $display("[TB] FAIL fwd_first got fwd=%b data=%h exp 1/11", ld_fwd, ld_data);
        end
        drive(1'b0, 32'h0, 32'h0, 1'b1, 32'd5);
        checks++; if (ld_fwd !== 1'b1 || ld_data !== 32'h22) begin
            failures++; $display("[TB] FAIL fwd_youngest got fwd=%b data=%h exp 1/22", ld_fwd, ld_data);
        end
        checks++; if (mem_write_enable !== 1'b0 || mem_read_enable !== 1'b1 || mem_addr !== 32'd5) begin
            failures++; $display("[TB] FAIL fwd_stall got wen=%b ren=%b addr=%h exp 0/1/5", mem_write_enable, mem_read_enable, mem_addr);
        end
        drive(1'b0, 32'h0, 32'h0, 1'b0, 32'h0);
        checks++; if (mem_write_enable !== 1'b1 || mem_addr !== 32'd5 || mem_write_data !== FIRST_DRAIN_5) begin
            failures++; $display("[TB] FAIL fwd_drain got wen=%b addr=%h data=%h exp data=%h", mem_write_enable, mem_addr, mem_write_data, FIRST_DRAIN_5);
        end
        drive(1'b0, 32'h0, 32'h0, 1'b0, 32'h0);
        drive(1'b0, 32'h0, 32'h0, 1'b0, 32'h0);
        checks++; if (empty !== 1'b1 || mem[5] !== 32'h22) begin
            failures++; $display("[TB] FAIL fwd_final got empty=%b mem5=%h exp 1/22", empty, mem[5]);
        end
    endtask

    task automatic test_mem_read;
        drive(1'b0, 32'h0, 32'h0, 1'b1, 32'd7);
        checks++; if (ld_data !== 32'h77 || ld_fwd !== 1'b0) begin
            failures++; $display("[TB] FAIL mem_read_data got data=%h fwd=%b exp 77/0", ld_data, ld_fwd);
        end
        checks++; if (mem_read_enable !== 1'b1 || mem_addr !== 32'd7 || mem_write_enable !== 1'b0) begin
            failures++; $display("[TB] FAIL mem_read_port got ren=%b addr=%h wen=%b exp 1/7/0", mem_read_enable, mem_addr, mem_write_enable);
        end
        drive(1'b0, 32'h0, 32'h0, 1'b0, 32'd7);
        checks++; if (ld_data !== 32'h0 || mem_read_enable !== 1'b0) begin
            failures++; $display("[TB] FAIL no_load got data=%h ren=%b exp 0/0", ld_data, mem_read_enable);
        end
    endtask

    task automatic test_addr_zero;
        drive(1'b1, 32'h0, 32'hAB, 1'b0, 32'h0);
        checks++; if (st_ready !== 1'b1 || mem_write_enable !== 1'b0) begin
            failures++; $display("[TB] FAIL addr0_accept got ready=%b wen=%b exp 1/0", st_ready, mem_write_enable);
        end
        drive(1'b0, 32'h0, 32'h0, 1'b0, 32'h0);
        checks++; if (empty !== 1'b1 || mem_write_enable !== 1'b0) begin
            failures++; $display("[TB] FAIL addr0_not_queued got empty=%b wen=%b exp 1/0", empty, mem_write_enable);
        end
    endtask

    task automatic test_reset_mid_drain;
        for (int i = 1; i <= 4; i++) begin
            drive(1'b1, 32'(i), 32'hB0 + 32'(i), 1'b1, 32'd15);
        end
        drive(1'b0, 32'h0, 32'h0, 1'b0, 32'h0);
        checks++; if (mem_write_enable !== 1'b1 || mem_addr !== 32'd1 || mem_write_data !== 32'hB1) begin
            failures++; $display("[TB] FAIL rst_pre_drain got wen=%b addr=%h data=%h exp 1/1/b1", mem_write_enable, mem_addr, mem_write_data);
        end
        drive(1'b0, 32'h0, 32'h0, 1'b0, 32'h0);
        #2;
        reset = 1'b1;
        #1;
        checks++; if (empty !== 1'b1 || mem_write_enable !== 1'b0 || st_ready !== 1'b1 || ld_fwd !== 1'b0) begin
            failures++; $display("[TB] FAIL rst_async got empty=%b wen=%b ready=%b fwd=%b exp 1/0/1/0", empty, mem_write_enable, st_ready, ld_fwd);
        end
        @(negedge clk);
        reset = 1'b0;
        drive(1'b0, 32'h0, 32'h0, 1'b0, 32'h0);
        checks++; if (empty !== 1'b1 || mem_write_enable !== 1'b0) begin
            failures++; $display("[TB] FAIL rst_after got empty=%b wen=%b exp 1/0", empty, mem_write_enable);
        end
        checks++; if (mem[3] !== 32'hA3 || mem[4] !== 32'hA4) begin
            failures++; $display("[TB] FAIL rst_discard got mem3=%h mem4=%h exp a3/a4", mem[3], mem[4]);
        end
    endtask

    task automatic test_back_to_back;
        drive(1'b1, 32'd1, 32'h10, 1'b1, 32'd15);
        drive(1'b1, 32'd2, 32'h20, 1'b1, 32'd15);
        for (int k = 0; k < 5; k++) begin
            drive(1'b1, 32'(3 + k), 32'((3 + k) * 16), 1'b0, 32'h0);
            checks++; if (mem_write_enable !== 1'b1 || mem_addr !== 32'(k + 1) || mem_write_data !== 32'((k + 1) * 16)) begin
                failures++; $display("[TB] FAIL b2b_drain_%0d got wen=%b addr=%h data=%h exp addr=%0d", k, mem_write_enable, mem_addr, mem_write_data, k + 1);
            end
            checks++; if (st_ready !== 1'b1 || empty !== 1'b0) begin
                failures++; $display("[TB] FAIL b2b_state_%0d got ready=%b empty=%b exp 1/0", k, st_ready, empty);
            end
        end
        for (int k = 5; k < 7; k++) begin
            drive(1'b0, 32'h0, 32'h0, 1'b0, 32'h0);
            checks++; if (mem_write_enable !== 1'b1 || mem_addr !== 32'(k + 1) || mem_write_data !== 32'((k + 1) * 16)) begin
                failures++; $display("[TB] FAIL b2b_tail_%0d got wen=%b addr=%h data=%h exp addr=%0d", k, mem_write_enable, mem_addr, mem_write_data, k + 1);
            end
        end
        drive(1'b0, 32'h0, 32'h0, 1'b0, 32'h0);
        checks++; if (empty !== 1'b1 || mem_write_enable !== 1'b0) begin
            failures++; $display("[TB] FAIL b2b_end got empty=%b wen=%b exp 1/0", empty, mem_write_enable);
        end
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        reset    = 1'b1;
        st_valid = 1'b0;
        st_addr  = '0;
        st_data  = '0;
        ld_req   = 1'b0;
        ld_addr  = '0;
        for (int i = 0; i < 16; i++) mem[i] = 32'h0;
        mem[7] = 32'h77;
        test_reset;
        test_fill_drain;
        test_latency;
        test_forward;
        test_mem_read;
        test_addr_zero;
        test_reset_mid_drain;
        test_back_to_back;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
